// File: rtl/gat_pkg.sv
// Shared definitions for the feature-path blocks: default feature BRAM geometry
// and the loader FSM state type.
package gat_pkg;

  localparam int unsigned FEAT_NUM_WORDS = 43328;
  localparam int unsigned FEAT_DATA_W    = 32;
  localparam int unsigned FEAT_ADDR_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/feat_bram_loader.sv
// Feature BRAM write-side loader: valid/ready stream in, port-A writes out at consecutive addresses.
// Optional running checksum of written words is built only when FEAT_LOADER_CHECKSUM_EN is defined.
module feat_bram_loader
  import gat_pkg::*;
#(
  parameter int unsigned DATA_W    = FEAT_DATA_W,
  parameter int unsigned ADDR_W    = FEAT_ADDR_W,
  parameter int unsigned NUM_WORDS = FEAT_NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_vld_i,
  input  logic              s_last_i,
  output logic              s_rdy_o,
  output logic [DATA_W-1:0] feat_bram_din,
  output logic              feat_bram_ena,
  output logic [ADDR_W-1:0] feat_bram_addra,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic [DATA_W-1:0] checksum_o
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_WORDS - 1);

  loader_state_t state;
  logic          accept;
  logic          start_load;
  logic          last_beat;

  assign accept     = s_vld_i && s_rdy_o;
  assign start_load = start_i && ((state == IDLE) || (state == DONE));
  assign last_beat  = (word_cnt_o == LAST_IDX);

  // word_cnt_o doubles as the address counter; it never exceeds LAST_IDX on a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      s_rdy_o         <= 1'b0;
      feat_bram_din   <= '0;
      feat_bram_ena   <= 1'b0;
      feat_bram_addra <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      word_cnt_o      <= '0;
    end else begin
      feat_bram_ena <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_load) begin
            state      <= LOAD;
            s_rdy_o    <= 1'b1;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            word_cnt_o <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            feat_bram_din   <= s_data_i;
            feat_bram_addra <= word_cnt_o[ADDR_W-1:0];
            feat_bram_ena   <= 1'b1;
            word_cnt_o      <= word_cnt_o + (ADDR_W+1)'(1);
            if (last_beat) begin
              state   <= FLUSH;
              s_rdy_o <= 1'b0;
              if (!s_last_i) err_o <= 1'b1;
            end else if (s_last_i) begin
              err_o <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEAT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (start_load) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + s_data_i;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_feat_bram_loader.sv
// Directed bench for feat_bram_loader with NUM_WORDS = 4.
module tb_feat_bram_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
`ifdef FEAT_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [DW-1:0] s_data_i;
  logic          s_vld_i;
  logic          s_last_i;
  logic          s_rdy_o;
  logic [DW-1:0] feat_bram_din;
  logic          feat_bram_ena;
  logic [AW-1:0] feat_bram_addra;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [AW:0]   word_cnt_o;
  logic [DW-1:0] checksum_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  feat_bram_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .s_data_i(s_data_i),
    .s_vld_i(s_vld_i), .s_last_i(s_last_i), .s_rdy_o(s_rdy_o),
    .feat_bram_din(feat_bram_din), .feat_bram_ena(feat_bram_ena),
    .feat_bram_addra(feat_bram_addra), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .word_cnt_o(word_cnt_o), .checksum_o(checksum_o)
  );

  typedef struct {
    bit        start, vld, last;
    bit [31:0] data;
    bit        rdy, ena, busy, done, err;
    bit [15:0] addra;
    bit [31:0] din;
    bit [16:0] cnt;
    bit [31:0] sum;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit st, bit v, bit l, bit [31:0] d, bit r, bit e, bit b,
                              bit dn, bit er, bit [15:0] a, bit [31:0] di, bit [16:0] c,
                              bit [31:0] s);
    vec_t t;
    t.start = st; t.vld = v; t.last = l; t.data = d;
    t.rdy = r; t.ena = e; t.busy = b; t.done = dn; t.err = er;
    t.addra = a; t.din = di; t.cnt = c; t.sum = s;
    return t;
  endfunction

  function automatic logic [63:0] exp_sum(logic [31:0] s);
    return CK ? {32'd0, s} : 64'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit st, input bit v, input bit l, input logic [31:0] d);
    start_i = st; s_vld_i = v; s_last_i = l; s_data_i = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    bit v;

    rst_n = 1'b0;
    drive(0, 0, 0, '0);
    #12;
    chk("rst_rdy",  s_rdy_o, 0);
    chk("rst_ena",  feat_bram_ena, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err",  err_o, 0);
    chk("rst_din",  feat_bram_din, 0);
    chk("rst_addr", feat_bram_addra, 0);
    chk("rst_cnt",  word_cnt_o, 0);
    chk("rst_sum",  checksum_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back load, valid held after the last beat, error load restarted from DONE
    vecs.push_back(mk(1,0,0,32'h00, 1,0,1,0,0, 0,32'h00, 0, 32'h000));
    vecs.push_back(mk(0,1,0,32'hA0, 1,1,1,0,0, 0,32'hA0, 1, 32'h0A0));
    vecs.push_back(mk(0,1,0,32'hA1, 1,1,1,0,0, 1,32'hA1, 2, 32'h141));
    vecs.push_back(mk(0,1,0,32'hA2, 1,1,1,0,0, 2,32'hA2, 3, 32'h1E3));
    vecs.push_back(mk(0,1,1,32'hA3, 0,1,1,0,0, 3,32'hA3, 4, 32'h286));
    vecs.push_back(mk(0,1,0,32'hA4, 0,0,0,1,0, 3,32'hA3, 4, 32'h286));
    vecs.push_back(mk(0,1,1,32'hA5, 0,0,0,1,0, 3,32'hA3, 4, 32'h286));
    vecs.push_back(mk(1,0,0,32'h00, 1,0,1,0,0, 3,32'hA3, 0, 32'h000));
    vecs.push_back(mk(1,1,0,32'hB0, 1,1,1,0,0, 0,32'hB0, 1, 32'h0B0));
    vecs.push_back(mk(0,1,1,32'hB1, 1,1,1,0,1, 1,32'hB1, 2, 32'h161));
    vecs.push_back(mk(0,1,0,32'hB2, 1,1,1,0,1, 2,32'hB2, 3, 32'h213));
    vecs.push_back(mk(0,1,0,32'hB3, 0,1,1,0,1, 3,32'hB3, 4, 32'h2C6));
    vecs.push_back(mk(1,0,0,32'h00, 0,0,0,1,1, 3,32'hB3, 4, 32'h2C6));
    vecs.push_back(mk(1,0,0,32'h00, 1,0,1,0,0, 3,32'hB3, 0, 32'h000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].vld, vecs[i].last, vecs[i].data);
      step();
      chk($sformatf("v%0d_rdy", i),  s_rdy_o,         vecs[i].rdy);
      chk($sformatf("v%0d_ena", i),  feat_bram_ena,   vecs[i].ena);
      chk($sformatf("v%0d_busy", i), busy_o,          vecs[i].busy);
      chk($sformatf("v%0d_done", i), done_o,          vecs[i].done);
      chk($sformatf("v%0d_err", i),  err_o,           vecs[i].err);
      chk($sformatf("v%0d_addr", i), feat_bram_addra, vecs[i].addra);
      chk($sformatf("v%0d_din", i),  feat_bram_din,   vecs[i].din);
      chk($sformatf("v%0d_cnt", i),  word_cnt_o,      vecs[i].cnt);
      chk($sformatf("v%0d_sum", i),  checksum_o,      exp_sum(vecs[i].sum));
    end

    // random valid gaps on the load just started
    acc = 0;
    for (int c = 0; c < 200 && acc < 4; c++) begin
      v = 1'($urandom_range(0, 1));
      drive(0, v, acc == 3, 32'hC0 + 32'(acc));
      step();
      chk("gap_ena", feat_bram_ena, v);
      if (v) begin
        chk("gap_addr", feat_bram_addra, acc);
        chk("gap_din",  feat_bram_din, 32'hC0 + 32'(acc));
        acc++;
      end
    end
    chk("gap_beats", acc, 4);
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 32'hCC);
      step();
      chk("gap_no_extra_ena", feat_bram_ena, 0);
      chk("gap_rdy_low", s_rdy_o, 0);
    end
    chk("gap_done", done_o, 1);
    chk("gap_err",  err_o, 0);
    chk("gap_cnt",  word_cnt_o, 4);
    chk("gap_sum",  checksum_o, exp_sum(32'h306));

    // asynchronous reset in the middle of a load
    drive(1, 0, 0, '0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'hD0 + 32'(i));
      step();
    end
    chk("mid_ena_before", feat_bram_ena, 1);
    chk("mid_addr_before", feat_bram_addra, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ena",  feat_bram_ena, 0);
    chk("mid_rst_rdy",  s_rdy_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_addr", feat_bram_addra, 0);
    chk("mid_rst_din",  feat_bram_din, 0);
    chk("mid_rst_cnt",  word_cnt_o, 0);
    chk("mid_rst_sum",  checksum_o, 0);
    drive(0, 0, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle_rdy", s_rdy_o, 0);
    drive(1, 0, 0, '0);
    step();
    chk("restart_rdy", s_rdy_o, 1);
    drive(0, 1, 0, 32'hD8);
    step();
    chk("restart_ena",  feat_bram_ena, 1);
    chk("restart_addr", feat_bram_addra, 0);
    chk("restart_din",  feat_bram_din, 32'hD8);
    chk("restart_cnt",  word_cnt_o, 1);
    drive(0, 0, 0, '0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/feat_bram_loader.md
# feat_bram_loader

Write-side front end of the feature BRAM. It accepts a valid/ready word stream from the host DMA path and drives the feature BRAM port A (`feat_bram_din`, `feat_bram_ena`, `feat_bram_addra`) with consecutive addresses. It signals completion to the top-level control. It also flags stream framing errors so that bring-up can tell a short or long transfer apart from a datapath fault.

## Interface
Parameters:
- `DATA_W`, 32: feature word width.
- `ADDR_W`, 16: BRAM address width.
- `NUM_WORDS`, 43328: words per load. Legal range is 1 to 2^ADDR_W.

Ports (clk, rst_n first):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: level; begins a load when sampled high in IDLE or DONE.
- `s_data_i`, in, DATA_W: stream data.
- `s_vld_i`, in, 1: stream valid.
- `s_last_i`, in, 1: marks the final beat.
- `s_rdy_o`, out, 1: stream ready.
- `feat_bram_din`, out, DATA_W: BRAM write data.
- `feat_bram_ena`, out, 1: BRAM enable/write strobe.
- `feat_bram_addra`, out, ADDR_W: BRAM address.
- `busy_o`, out, 1: high in LOAD or FLUSH.
- `done_o`, out, 1: high in DONE.
- `err_o`, out, 1: sticky framing error.
- `word_cnt_o`, out, ADDR_W+1: beats accepted in the current load.
- `checksum_o`, out, DATA_W: see Configuration.

## Operation
- FSM states are IDLE, LOAD, FLUSH and DONE. Reset state is IDLE.
- IDLE → LOAD when `start_i` is high. DONE → LOAD when `start_i` is high. On entering LOAD:
  - the address counter and `word_cnt_o` clear to 0;
  - `err_o` clears.
- `start_i` is ignored in LOAD and FLUSH.
- `s_rdy_o` is high only in LOAD. It is a registered state decode and never depends combinationally on `s_vld_i`.
- A beat is accepted when `s_vld_i && s_rdy_o`. Each accepted beat:
  - registers `din` = `s_data_i` and `addra` = address counter;
  - registers `ena` = 1;
  - increments the address counter and `word_cnt_o`.
- Cycles with no accepted beat drive `ena` = 0. `din` and `addra` hold their last value.
- LOAD → FLUSH on acceptance of beat `NUM_WORDS-1`. FLUSH lasts one cycle, carries the final write, then goes to DONE.
- DONE holds `done_o` high until the next start.
- Framing errors set `err_o`:
  - `s_last_i` high on any accepted beat other than index `NUM_WORDS-1`;
  - `s_last_i` low on beat index `NUM_WORDS-1`.
- A framing error does not abort the load. The length is always exactly `NUM_WORDS`, and extra beats are back-pressured by `s_rdy_o` = 0.
- Addresses never wrap within a load. The counter cannot exceed `NUM_WORDS-1` on a write.

## Timing
- Acceptance in cycle N produces the BRAM write in cycle N+1, so latency is 1.
- Sustained throughput is 1 word/cycle.
- Last beat accepted in cycle N:
  - FLUSH in N+1, with `ena` high for the last write;
  - `done_o` high from N+2.
- `busy_o` rises the cycle after `start_i` is sampled. It falls in the same cycle `done_o` rises.
- Reset values:
  - `s_rdy_o`, `feat_bram_ena`, `busy_o`, `done_o`, `err_o` = 0;
  - `feat_bram_din`, `feat_bram_addra`, `word_cnt_o`, `checksum_o` = 0.
- Reset mid-load forces IDLE immediately. The pending write is dropped because `ena` goes to 0 asynchronously.
- `NUM_WORDS` = 1: the first beat goes directly LOAD → FLUSH.

## Configuration
- `FEAT_LOADER_CHECKSUM_EN` defined:
  - `checksum_o` is the modulo-2^DATA_W sum of all words written in the current load;
  - it clears on load start and updates in the same cycle as the write (`ena` high);
  - it is stable from `done_o` rise.
- Undefined: `checksum_o` is tied to 0 and the adder is not built.

## Structure
- Shared package `gat_pkg` holds:
  - `FEAT_NUM_WORDS` (43328);
  - `FEAT_DATA_W` and `FEAT_ADDR_W`;
  - typedef enum `loader_state_t` {IDLE, LOAD, FLUSH, DONE}.
- There is no sub-module. The counter, FSM and write register are inline; the block is small enough.

## Test plan
- Reset, then `NUM_WORDS`=4 and start. Stream 0xA0..0xA3 with `s_last_i` on beat 3. Required:
  - writes to addra 0..3, each one cycle after its accept;
  - `done_o` 2 cycles after the last accept;
  - `err_o`=0;
  - `checksum_o`=0x286 with the macro, 0 without.
- Random `s_vld_i` gaps (50%). Required: `ena` pulses exactly 4 times, with contiguous addresses and data order preserved.
- `s_last_i` on beat 1 of 4. Required: `err_o` rises the cycle after beat 1, the load still completes 4 writes, and `done_o` rises.
- `s_vld_i` held high after the 4th beat. Required: `s_rdy_o`=0 from FLUSH onward, and no 5th write.
- Assert `rst_n` low after beat 2. Required: all outputs reset immediately. A fresh start rewrites from addra 0.
- `start_i` held in DONE. Required: a second load begins, `word_cnt_o` returns to 0, and `err_o` clears.
